// File: rtl/sng_array.sv
// Multi-lane stochastic number generator.
// Each lane turns an unsigned operand into a unary-weighted bitstream:
// quota -> Weyl-sequence bit placement -> phase rotation. The rotation
// phase comes from a beat counter offset by the lane index, so lanes that
// carry equal operands still produce decorrelated streams.
// Two pipeline stages with valid/ready chaining on both sides.
module sng_array #(
  parameter int LANES     = 4,
  parameter int BITSTREAM = 64,
  parameter int BASE      = 61,
  parameter int STRIDE    = 17,
  parameter int QUANT     = 8,
  parameter int PHASE_W   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [LANES*QUANT-1:0]         in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  input  logic                           phase_bypass,
  output logic [LANES*BITSTREAM-1:0]     out_bits,
  output logic                           out_valid,
  output logic                           out_last,
  input  logic                           out_ready
);

  localparam int LOG2BS = $clog2(BITSTREAM);
  localparam int QW     = LOG2BS + 1;           // quota width, holds 0..BITSTREAM
  localparam int PROD_W = QUANT + LOG2BS + 1;   // d*BITSTREAM + rounding half
  localparam int HALF   = 2 ** (QUANT - 1);
  localparam int STEP   = BITSTREAM >> PHASE_W; // rotation granule per phase

  // Parameter legality is checked at elaboration time.
  if ((BITSTREAM & (BITSTREAM - 1)) != 0 || BITSTREAM < 8 || BITSTREAM > 256) begin : g_bad_bitstream
    $error("sng_array: BITSTREAM must be a power of two in 8..256");
  end
  if (BASE < 0 || BASE >= BITSTREAM) begin : g_bad_base
    $error("sng_array: BASE must lie in 0..BITSTREAM-1");
  end
  if (STRIDE % 2 == 0) begin : g_bad_stride
    $error("sng_array: STRIDE must be odd so the Weyl walk visits every bit");
  end
  if (PHASE_W < 1 || PHASE_W > LOG2BS) begin : g_bad_phase
    $error("sng_array: PHASE_W must be in 1..log2(BITSTREAM)");
  end
  if (LANES < 1 || QUANT < 1) begin : g_bad_shape
    $error("sng_array: LANES and QUANT must be positive");
  end

  // Full per-lane transform: rounded quota, Weyl placement, left rotation.
  function automatic logic [BITSTREAM-1:0] lane_stream(
    input logic [QUANT-1:0]   d,
    input logic [PHASE_W-1:0] lk,
    input logic               byp
  );
    logic [PROD_W-1:0]    scaled;
    logic [PROD_W-1:0]    q_full;
    logic [QW-1:0]        q;
    logic [BITSTREAM-1:0] pat;
    logic [LOG2BS-1:0]    r;
    scaled = (PROD_W'(d) << LOG2BS) + PROD_W'(HALF);
    q_full = scaled >> QUANT;
    q      = (q_full > PROD_W'(BITSTREAM)) ? QW'(BITSTREAM) : q_full[QW-1:0];
    // Step j of the Weyl walk lands on a fixed bit; it is lit when j < q.
    // STRIDE is odd, so positions never collide and popcount equals q.
    pat = '0;
    for (int j = 0; j < BITSTREAM; j++) begin
      if (QW'(j) < q) pat[LOG2BS'((BASE + j * STRIDE) % BITSTREAM)] = 1'b1;
    end
    r = byp ? '0 : LOG2BS'(int'(lk) * STEP);
    // With r = 0 the right shift is by the full width and contributes 0.
    return (pat << r) | (pat >> (BITSTREAM - int'(r)));
  endfunction

  // Pipeline state.
  logic                       v1, v2;
  logic [LANES*QUANT-1:0]     s1_data;
  logic [PHASE_W-1:0]         s1_k;
  logic                       s1_bypass;
  logic                       s1_last;
  logic [PHASE_W-1:0]         k;
  logic [LANES*BITSTREAM-1:0] nxt_bits;
  logic                       s1_ready, s2_ready, accept;

  // Ready chain: a stage may load when it is empty or its contents move on.
  assign s2_ready  = !v2 || out_ready;
  assign s1_ready  = !v1 || s2_ready;
  assign in_ready  = s1_ready;
  assign accept    = in_valid && s1_ready;
  assign out_valid = v2;

  // Stage 1: capture the operand beat with the phase it must use.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  // NOTE: payload registers are reset along with the valids so the outputs
  // read as zero during and right after reset, not stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      s1_data   <= '0;
      s1_k      <= '0;
      s1_bypass <= 1'b0;
      s1_last   <= 1'b0;
      k         <= '0;
    end else begin
      if (s1_ready) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1_data   <= in_data;
          s1_k      <= k;
          s1_bypass <= phase_bypass;
          s1_last   <= in_last;
        end
      end
      if (accept) k <= in_last ? '0 : k + PHASE_W'(1);
    end
  end

  // Per-lane bitstream generation from the stage-1 registers.
  // NOTE: default assignment first so every path drives nxt_bits and no
  // latch is inferred.
  always_comb begin
    nxt_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      nxt_bits[i*BITSTREAM +: BITSTREAM] =
        lane_stream(s1_data[i*QUANT +: QUANT], s1_k + PHASE_W'(i), s1_bypass);
    end
  end

  // Stage 2: register the finished bitstreams; hold them while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2       <= 1'b0;
      out_bits <= '0;
      out_last <= 1'b0;
    end else if (s2_ready) begin
      v2 <= v1;
      if (v1) begin
        out_bits <= nxt_bits;
        out_last <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_sng_array.sv
// Self-checking bench for sng_array: a value-level model drives a
// scoreboard checked on every output handshake, plus directed vectors with
// hand-computed bit patterns.
module tb_sng_array;

  localparam int LANES     = 4;
  localparam int BS        = 64;
  localparam int BASE      = 61;
  localparam int STRIDE    = 17;
  localparam int QUANT     = 8;
  localparam int PHASE_W   = 2;
  localparam int OW        = LANES * BS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [LANES*QUANT-1:0] in_data;
  logic              in_valid, in_last, in_ready, phase_bypass;
  logic [OW-1:0]     out_bits;
  logic              out_valid, out_last, out_ready;

  sng_array #(
    .LANES(LANES), .BITSTREAM(BS), .BASE(BASE), .STRIDE(STRIDE),
    .QUANT(QUANT), .PHASE_W(PHASE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .phase_bypass(phase_bypass),
    .out_bits(out_bits), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: straight from the definitions -- rounded quota, the first q
  // Weyl positions, each shifted by the lane's rotation amount.
  function automatic logic [BS-1:0] lane_model(input int d, input int lane, input int k, input bit byp);
    logic [BS-1:0] b = '0;
    int q, r;
    q = (d * BS + (1 << (QUANT - 1))) >> QUANT;
    if (q > BS) q = BS;
    r = byp ? 0 : ((k + lane) % (1 << PHASE_W)) * (BS >> PHASE_W);
    for (int j = 0; j < q; j++) b[(BASE + j * STRIDE + r) % BS] = 1'b1;
    return b;
  endfunction

  function automatic logic [OW-1:0] full_model(input logic [LANES*QUANT-1:0] data, input int k, input bit byp);
    logic [OW-1:0] res = '0;
    for (int l = 0; l < LANES; l++)
      res[l*BS +: BS] = lane_model(int'(data[l*QUANT +: QUANT]), l, k, byp);
    return res;
  endfunction

  typedef struct packed {
    logic [OW-1:0] bits;
    logic          last;
  } beat_t;

  beat_t         sb[$];
  logic [OW-1:0] em_bits[$];
  logic          em_last[$];
  int            model_k = 0;
  bit            stalled = 0;
  logic [OW-1:0] hold_bits;
  logic          hold_last;

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      sb.delete();
      model_k = 0;
      stalled = 0;
    end else begin
      if (out_valid && out_ready) begin
        em_bits.push_back(out_bits);
        em_last.push_back(out_last);
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected none", out_bits);
        end else begin
          e = sb.pop_front();
          check("sb_bits", out_bits, e.bits);
          check("sb_last", OW'(out_last), OW'(e.last));
        end
      end
      if (out_valid && !out_ready) begin
        if (stalled) begin
          check("stall_bits", out_bits, hold_bits);
          check("stall_last", OW'(out_last), OW'(hold_last));
        end
        stalled   = 1;
        hold_bits = out_bits;
        hold_last = out_last;
      end else begin
        stalled = 0;
      end
      if (in_valid && in_ready) begin
        e.bits = full_model(in_data, model_k, phase_bypass);
        e.last = in_last;
        sb.push_back(e);
        model_k = in_last ? 0 : (model_k + 1) % (1 << PHASE_W);
      end
    end
  end

  // Drive one beat and hold it until accepted (bounded).
  task automatic send(input logic [LANES*QUANT-1:0] data, input logic last, input logic byp);
    int n = 0;
    bit acc = 0;
    in_data = data; in_last = last; phase_bypass = byp; in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0; in_last = 1'b0; phase_bypass = 1'b0;
    if (!acc) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  localparam logic [BS-1:0] B61 = 64'h2000_0000_0000_0000;
  localparam logic [BS-1:0] B13 = 64'h0000_0000_0000_2000;
  localparam logic [BS-1:0] B29 = 64'h0000_0000_2000_0000;
  localparam logic [BS-1:0] B45 = 64'h0000_2000_0000_0000;

  initial begin
    logic [BS-1:0]          exp5 [5];
    logic [OW-1:0]          snap;
    logic [BS-1:0]          lane;
    logic [LANES*QUANT-1:0] stall_data [4];

    exp5 = '{B61, B13, B29, B61, B13};
    stall_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    phase_bypass = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", OW'(out_valid), '0);
    check("rst_out_bits", out_bits, '0);
    check("rst_out_last", OW'(out_last), '0);
    rst_n = 1'b1;
    check("rst_in_ready", OW'(in_ready), OW'(1));

    // Extremes: 0x00 -> all zero, 0xFF -> all ones, latency two cycles.
    send({LANES{8'h00}}, 1'b0, 1'b0);
    check("lat_not_yet", OW'(out_valid), '0);
    send({LANES{8'hFF}}, 1'b1, 1'b0);
    check("zero_valid", OW'(out_valid), OW'(1));
    check("zero_bits", out_bits, '0);
    @(posedge clk);
    #1;
    check("ones_valid", OW'(out_valid), OW'(1));
    check("ones_bits", out_bits, {OW{1'b1}});
    check("ones_last", OW'(out_last), OW'(1));
    wait_drain();

    // q = 1 on every lane, k = 0: lane i rotated by 16*i.
    send({LANES{8'h04}}, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("q1_lanes", out_bits, {B45, B29, B13, B61});
    wait_drain();

    // Five beats, in_last on the third: k runs 0,1,2,0,1.
    em_bits.delete(); em_last.delete();
    for (int i = 0; i < 5; i++) send(32'h0000_0004, i == 2, 1'b0);
    wait_drain();
    check("seq_count", OW'(em_bits.size()), OW'(5));
    for (int i = 0; i < 5 && i < em_bits.size(); i++) begin
      check($sformatf("seq_bits%0d", i), OW'(em_bits[i][BS-1:0]), OW'(exp5[i]));
      check($sformatf("seq_last%0d", i), OW'(em_last[i]), OW'(i == 2));
    end

    // q = 32 with bypass: pure Weyl pattern, identical on every lane.
    send({LANES{8'h80}}, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    for (int l = 0; l < LANES; l++) begin
      lane = out_bits[l*BS +: BS];
      check($sformatf("half_pop%0d", l), OW'($countones(lane)), OW'(32));
      check($sformatf("half_pos%0d", l), OW'({lane[61], lane[14], lane[31], lane[48]}), OW'(4'hF));
      check($sformatf("half_eq%0d", l), OW'(lane), OW'(B61 >> 61 == 1 ? out_bits[BS-1:0] : '0));
    end
    wait_drain();

    // Backpressure: four beats against a stalled output.
    em_bits.delete(); em_last.delete();
    out_ready = 1'b0;
    send(stall_data[0], 1'b0, 1'b0);
    send(stall_data[1], 1'b0, 1'b0);
    check("stall_in_ready", OW'(in_ready), '0);
    snap = out_bits;
    fork
      begin
        send(stall_data[2], 1'b0, 1'b0);
        send(stall_data[3], 1'b1, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        check("stall_snap", out_bits, snap);
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_count", OW'(em_bits.size()), OW'(4));
    for (int i = 0; i < 4 && i < em_bits.size(); i++)
      check($sformatf("stall_order%0d", i), em_bits[i], full_model(stall_data[i], i, 1'b0));

    // Reset with two beats in flight; the next beat restarts at k = 0.
    send({LANES{8'h04}}, 1'b0, 1'b0);
    send({LANES{8'h04}}, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", OW'(out_valid), '0);
    check("mid_rst_bits", out_bits, '0);
    check("mid_rst_last", OW'(out_last), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_ready", OW'(in_ready), OW'(1));
    send({LANES{8'h04}}, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("post_rst_k0", out_bits, {B45, B29, B13, B61});
    wait_drain();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
